// File: rtl/puf_result_uploader.sv
// Captures the PUF test FSM result-memory writes into a local RAM and uploads them as one
// framed valid/ready burst. Define PUF_UPLOAD_CSUM_EN to append the trailing checksum byte.
module puf_result_uploader #(
  parameter int         ADDR_WIDTH = 13,
  parameter int         DEPTH      = 512,
  parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
  input  logic                  clk_1,
  input  logic                  rst,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [7:0]            mem_din,
  input  logic                  test_done,
  input  logic                  rd_start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  armed,
  output logic                  overflow
);

  localparam int                    AW      = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    CAPTURE, ARMED, HDR, LEN_H, LEN_L, PAYLOAD, CSUM, FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] max_addr, max_nxt;
  logic          seen, seen_nxt;
  logic [15:0]   len, len_nxt;
  logic [15:0]   rd_cnt;
  logic [7:0]    rd_data;
  logic          rd_fresh;
  logic          in_range, wr_ok, accept, last_pay;
`ifdef PUF_UPLOAD_CSUM_EN
  logic [7:0]    csum;
`endif

  assign in_range = (mem_waddr < DEPTH_A);
  assign wr_ok    = (state == CAPTURE) && mem_we && in_range;
  assign accept   = out_valid && out_ready;
  assign last_pay = (rd_cnt == len - 16'd1);

  // Same-cycle write is folded in so a write alongside test_done still counts in len
  always_comb begin
    max_nxt  = max_addr;
    seen_nxt = seen;
    if (wr_ok) begin
      seen_nxt = 1'b1;
      if (mem_waddr[AW-1:0] > max_addr) max_nxt = mem_waddr[AW-1:0];
    end
    len_nxt = seen_nxt ? (16'(max_nxt) + 16'd1) : 16'd0;
  end

  always_ff @(posedge clk_1) begin
    if (wr_ok) mem[mem_waddr[AW-1:0]] <= mem_din;
    rd_data <= mem[rd_cnt[AW-1:0]];
  end

  always_ff @(posedge clk_1) begin
    if (rst) state <= CAPTURE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (test_done) state_nxt = ARMED;
      ARMED:   if (rd_start) state_nxt = HDR;
      HDR:     if (accept) state_nxt = LEN_H;
      LEN_H:   if (accept) state_nxt = LEN_L;
`ifdef PUF_UPLOAD_CSUM_EN
      LEN_L:   if (accept) state_nxt = (len == 16'd0) ? CSUM : PAYLOAD;
      PAYLOAD: if (accept && last_pay) state_nxt = CSUM;
      CSUM:    if (accept) state_nxt = FINISH;
`else
      LEN_L:   if (accept) state_nxt = (len == 16'd0) ? FINISH : PAYLOAD;
      PAYLOAD: if (accept && last_pay) state_nxt = FINISH;
`endif
      FINISH:  if (!test_done) state_nxt = CAPTURE;
      default: state_nxt = CAPTURE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    armed     = 1'b0;
    case (state)
      ARMED: armed = 1'b1;
      HDR: begin
        out_valid = 1'b1;
        out_data  = HDR_BYTE;
      end
      LEN_H: begin
        out_valid = 1'b1;
        out_data  = len[15:8];
      end
      LEN_L: begin
        out_valid = 1'b1;
        out_data  = len[7:0];
`ifndef PUF_UPLOAD_CSUM_EN
        out_last  = (len == 16'd0);
`endif
      end
      PAYLOAD: begin
        // RAM read lags the pointer by a cycle; hide the stale word right after an advance
        out_valid = rd_fresh;
        out_data  = rd_data;
`ifndef PUF_UPLOAD_CSUM_EN
        out_last  = last_pay;
`endif
      end
`ifdef PUF_UPLOAD_CSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      max_addr <= '0;
      seen     <= 1'b0;
      overflow <= 1'b0;
      len      <= 16'd0;
      rd_cnt   <= 16'd0;
      rd_fresh <= 1'b0;
`ifdef PUF_UPLOAD_CSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      rd_fresh <= 1'b1;
      case (state)
        CAPTURE: begin
          max_addr <= max_nxt;
          seen     <= seen_nxt;
          if (mem_we && !in_range) overflow <= 1'b1;
          if (test_done) begin
            len <= len_nxt;
`ifdef PUF_UPLOAD_CSUM_EN
            csum <= len_nxt[15:8] + len_nxt[7:0];
`endif
          end
        end
        ARMED: rd_cnt <= 16'd0;
        PAYLOAD: begin
          if (accept) begin
`ifdef PUF_UPLOAD_CSUM_EN
            csum <= csum + rd_data;
`endif
            if (!last_pay) begin
              rd_cnt   <= rd_cnt + 16'd1;
              rd_fresh <= 1'b0;
            end
          end
        end
        FINISH: begin
          if (!test_done) begin
            max_addr <= '0;
            seen     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_result_uploader.sv
// Scoreboard bench for puf_result_uploader: a byte-level frame model feeds an expected queue,
// and a monitor pops and compares every accepted byte. Honours PUF_UPLOAD_CSUM_EN.
module tb_puf_result_uploader;

`ifdef PUF_UPLOAD_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk_1 = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [12:0] mem_waddr = '0;
  logic [7:0]  mem_din = '0;
  logic        test_done = 1'b0;
  logic        rd_start = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, armed, overflow;
  logic [7:0]  out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];
  logic [7:0] ref_mem[512];
  bit         ref_seen = 0;
  int         ref_max = 0;
  bit         ref_ovf = 0;
  int         ready_mode = 0;
  bit         mon_en = 1;

  puf_result_uploader dut (
    .clk_1(clk_1), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .test_done(test_done), .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .armed(armed), .overflow(overflow)
  );

  always #5 clk_1 = ~clk_1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_1);
    #1;
  endtask

  // host side: always ready, toggling, or random
  initial forever begin
    @(posedge clk_1);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    int         gap = 0;
    bit         in_frame = 0;
    bit         hold = 0;
    logic [8:0] held = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk_1);
      if (!mon_en) begin
        in_frame = 0; hold = 0; gap = 0;
        continue;
      end
      if (hold) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, held});
      hold = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %0h with last=%0b, expected no output", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {out_last, out_data}, e);
            if (in_frame) check("valid_gap_le1", int'(gap <= 1), 1);
            in_frame = !out_last;
            gap = 0;
          end
        end else begin
          hold = 1;
          held = {out_last, out_data};
        end
      end else if (in_frame) begin
        gap++;
      end
    end
  end

  task automatic model_write(input int addr, input logic [7:0] d);
    if (addr < 512) begin
      ref_mem[addr] = d;
      ref_seen = 1;
      if (addr > ref_max) ref_max = addr;
    end else begin
      ref_ovf = 1;
    end
  endtask

  task automatic wr(input int addr, input logic [7:0] d);
    mem_we = 1'b1;
    mem_waddr = 13'(addr);
    mem_din = d;
    model_write(addr, d);
    cyc();
    mem_we = 1'b0;
  endtask

  task automatic push_frame(output int nbytes);
    int          len;
    logic [15:0] l16;
    logic [7:0]  sum;
    len = ref_seen ? ref_max + 1 : 0;
    l16 = 16'(len);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, l16[15:8]});
    exp_q.push_back({(!CSUM_EN && len == 0), l16[7:0]});
    sum = l16[15:8] + l16[7:0];
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(!CSUM_EN && i == len - 1), ref_mem[i]});
      sum = sum + ref_mem[i];
    end
    if (CSUM_EN) exp_q.push_back({1'b1, sum});
    nbytes = exp_q.size();
  endtask

  task automatic close_capture(input bit same_write, input int sw_addr, input logic [7:0] sw_data);
    if (same_write) begin
      mem_we = 1'b1;
      mem_waddr = 13'(sw_addr);
      mem_din = sw_data;
      model_write(sw_addr, sw_data);
    end
    test_done = 1'b1;
    cyc();
    mem_we = 1'b0;
    @(negedge clk_1);
    check("armed_set", armed, 1);
    check("overflow_flag", overflow, ref_ovf);
    check("idle_valid", out_valid, 0);
    // a write while armed must not reach the RAM
    mem_we = 1'b1;
    mem_waddr = 13'd0;
    mem_din = ~ref_mem[0];
    cyc();
    mem_we = 1'b0;
  endtask

  task automatic upload_and_finish();
    int n;
    push_frame(n);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int i = 0; i < 4 * n + 40 && exp_q.size() != 0; i++) cyc();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: %0d bytes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    cyc();
    @(negedge clk_1);
    check("finish_valid", out_valid, 0);
    check("finish_armed", armed, 0);
    test_done = 1'b0;
    cyc();
    cyc();
    @(negedge clk_1);
    check("overflow_cleared", overflow, 0);
    ref_seen = 0; ref_max = 0; ref_ovf = 0;
  endtask

  task automatic scenario_basic();
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) wr(i, 8'(i + 1));
    close_capture(0, 0, 8'h00);
    upload_and_finish();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nw, a;
    repeat (3) cyc();
    @(negedge clk_1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_armed", armed, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    cyc();

    // full-depth session gives the model known RAM contents
    ready_mode = 2;
    for (int i = 0; i < 512; i++) wr(i, 8'($urandom));
    close_capture(0, 0, 8'h00);
    upload_and_finish();

    ready_mode = 0;
    scenario_basic();
    ready_mode = 1;
    scenario_basic();

    ready_mode = 0;
    close_capture(0, 0, 8'h00);
    upload_and_finish();

    ready_mode = 2;
    wr(600, 8'h5C);
    wr(5, 8'hAA);
    close_capture(0, 0, 8'h00);
    upload_and_finish();

    for (int s = 0; s < 8; s++) begin
      ready_mode = 2;
      nw = $urandom_range(0, 12);
      for (int i = 0; i < nw; i++) begin
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(512, 8191) : $urandom_range(0, 63);
        wr(a, 8'($urandom));
      end
      close_capture(1'($urandom_range(0, 1)), $urandom_range(0, 80), 8'($urandom));
      upload_and_finish();
    end

    // reset in the middle of the payload
    ready_mode = 0;
    for (int i = 0; i < 10; i++) wr(i, 8'($urandom));
    wr(700, 8'h11);
    close_capture(0, 0, 8'h00);
    push_frame(n);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > n - 6; i++) cyc();
    mon_en = 0;
    rst = 1'b1;
    test_done = 1'b0;
    cyc();
    @(negedge clk_1);
    check("midrst_valid", out_valid, 0);
    check("midrst_armed", armed, 0);
    check("midrst_overflow", overflow, 0);
    rst = 1'b0;
    exp_q.delete();
    ref_seen = 0; ref_max = 0; ref_ovf = 0;
    cyc();
    mon_en = 1;
    scenario_basic();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
